mode_counter: RTL and testbench

- Parametrised, runtime-configurable modulo counter for general timing and sequencing.
- Generalises the fixed-modulus up-counter:
  - adds width parameter, runtime modulus, up/down direction, synchronous clear and load;
  - adds wrap / saturate / one-shot modes, a registered terminal-count pulse and a one-shot done flag.
- Instantiated by prescalers, baud/tick generators and timeout logic.

---
 rtl/mode_counter.sv | 81 ++++++++
 tb/tb_mode_counter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mode_counter.sv
// rtl/mode_counter.sv - runtime-configurable modulo counter with wrap/saturate/one-shot modes
module mode_counter #(
    parameter int W = 23
) (
    input  logic         clk,
    input  logic         rst_,
    input  logic         ena,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] mod_val,
    input  logic         dir,
    input  logic [1:0]   mode,
    output logic [W-1:0] count,
    output logic         tc,
    output logic         done
);

    typedef enum logic [1:0] {
        MODE_WRAP     = 2'b00,
        MODE_SATURATE = 2'b01,
        MODE_ONESHOT  = 2'b10,
        MODE_WRAP_ALT = 2'b11
    } mode_t;

    logic [W:0]   m_ext;
    logic [W:0]   last_ext;
    logic [W:0]   count_ext;
    logic [W:0]   load_ext;
    logic [W-1:0] last_val;
    logic         at_terminal;
    mode_t        mode_sel;

    // One extra bit so a modulus of 2^W (mod_val == 0) and its M-1 compare never overflow.
    always_comb begin
        m_ext       = (mod_val == '0) ? {1'b1, {W{1'b0}}} : {1'b0, mod_val};
        last_ext    = m_ext - (W+1)'(1);
        last_val    = last_ext[W-1:0];
        count_ext   = {1'b0, count};
        load_ext    = {1'b0, load_val};
        at_terminal = dir ? (count_ext >= last_ext) : (count == '0);
        mode_sel    = mode_t'(mode);
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            count <= '0;
            tc    <= 1'b0;
            done  <= 1'b0;
        end else if (clr) begin
            count <= dir ? '0 : last_val;
            tc    <= 1'b0;
            done  <= 1'b0;
        end else if (load) begin
            count <= (load_ext > last_ext) ? last_val : load_val;
            tc    <= 1'b0;
            done  <= 1'b0;
        end else if (ena && !done) begin
            if (at_terminal) begin
                tc <= 1'b1;
                case (mode_sel)
                    MODE_SATURATE: count <= count;
                    MODE_ONESHOT:  done  <= 1'b1;
                    default:       count <= dir ? '0 : last_val;
                endcase
            end else begin
                tc <= 1'b0;
                if (dir)
                    count <= count + W'(1);
                else if (count_ext > last_ext)
                    // modulus lowered below the current count while counting down
                    count <= last_val;
                else
                    count <= count - W'(1);
            end
        end else begin
            tc <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mode_counter.sv
// tb/tb_mode_counter.sv - directed and randomized checks of mode_counter against a reference model
module tb_mode_counter;

    localparam int W = 4;
    localparam int FULL = 1 << W;

    logic         clk = 1'b0;
    logic         rst_ = 1'b0;
    logic         ena = 1'b0;
    logic         clr = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] mod_val = '0;
    logic         dir = 1'b1;
    logic [1:0]   mode = 2'b00;
    logic [W-1:0] count;
    logic         tc;
    logic         done;

    int errors = 0;
    int checks = 0;

    int exp_count = 0;
    int exp_tc = 0;
    int exp_done = 0;

    mode_counter #(.W(W)) dut (
        .clk(clk),
        .rst_(rst_),
        .ena(ena),
        .clr(clr),
        .load(load),
        .load_val(load_val),
        .mod_val(mod_val),
        .dir(dir),
        .mode(mode),
        .count(count),
        .tc(tc),
        .done(done)
    );

    always #5 clk = ~clk;

    // Behavioural rules in plain integer arithmetic: modulus M, range 0..M-1.
    task automatic model_step();
        int m;
        int hit_end;
        m = (int'(mod_val) == 0) ? FULL : int'(mod_val);
        if (clr) begin
            exp_count = dir ? 0 : m - 1;
            exp_tc = 0;
            exp_done = 0;
        end else if (load) begin
            exp_count = (int'(load_val) < m - 1) ? int'(load_val) : m - 1;
            exp_tc = 0;
            exp_done = 0;
        end else if (ena && exp_done == 0) begin
            hit_end = dir ? (exp_count >= m - 1) : (exp_count == 0);
            if (hit_end != 0) begin
                exp_tc = 1;
                if (mode == 2'b10) exp_done = 1;
                else if (mode != 2'b01) exp_count = dir ? 0 : m - 1;
            end else begin
                exp_tc = 0;
                if (dir) exp_count = exp_count + 1;
                else if (exp_count > m - 1) exp_count = m - 1;
                else exp_count = exp_count - 1;
            end
        end else begin
            exp_tc = 0;
        end
    endtask

    task automatic check(input string tag, input int got, input int want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".count"}, int'(count), exp_count);
        check({tag, ".tc"}, int'(tc), exp_tc);
        check({tag, ".done"}, int'(done), exp_done);
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) cycle(tag);
    endtask

    initial begin
        #12;
        check("reset.count", int'(count), 0);
        check("reset.tc", int'(tc), 0);
        check("reset.done", int'(done), 0);
        rst_ = 1'b1;
        #1;

        // wrap up, M=5
        mod_val = 4'd5; mode = 2'b00; dir = 1'b1; ena = 1'b1;
        run("wrap_up", 12);

        // wrap down, M=16
        ena = 1'b0; mod_val = 4'd0; dir = 1'b0; clr = 1'b1;
        cycle("clr_down");
        check("clr_down.start", int'(count), 15);
        clr = 1'b0; ena = 1'b1;
        run("wrap_down", 17);

        // saturate, M=3
        mode = 2'b01; mod_val = 4'd3; dir = 1'b1; clr = 1'b1;
        cycle("sat_clr");
        clr = 1'b0;
        run("saturate", 6);
        check("saturate.hold", int'(count), 2);

        // one-shot, M=4, then clamped load
        mode = 2'b10; mod_val = 4'd4; clr = 1'b1;
        cycle("os_clr");
        clr = 1'b0;
        run("oneshot", 7);
        check("oneshot.done", int'(done), 1);
        check("oneshot.frozen", int'(count), 3);
        load = 1'b1; load_val = 4'd9;
        cycle("os_load");
        check("os_load.clamp", int'(count), 3);
        load = 1'b0;

        // modulus lowered mid-run
        mode = 2'b00; mod_val = 4'd10; clr = 1'b1;
        cycle("mid_clr");
        clr = 1'b0;
        run("mid_up", 7);
        mod_val = 4'd5;
        cycle("mid_lower_up");
        check("mid_lower_up.count", int'(count), 0);
        check("mid_lower_up.tc", int'(tc), 1);
        mod_val = 4'd0; load = 1'b1; load_val = 4'd12;
        cycle("mid_load12");
        load = 1'b0; mod_val = 4'd5; dir = 1'b0;
        cycle("mid_lower_down");
        check("mid_lower_down.count", int'(count), 4);
        check("mid_lower_down.tc", int'(tc), 0);

        // M=1 in wrap and one-shot
        mod_val = 4'd1; dir = 1'b1; mode = 2'b00;
        run("m1_wrap", 3);
        mode = 2'b10; clr = 1'b1;
        cycle("m1_clr");
        clr = 1'b0;
        run("m1_oneshot", 3);

        // asynchronous reset between edges
        mode = 2'b00; mod_val = 4'd9; load = 1'b1; load_val = 4'd6;
        cycle("pre_rst_load");
        load = 1'b0;
        cycle("pre_rst_step");
        #3;
        rst_ = 1'b0;
        #1;
        exp_count = 0; exp_tc = 0; exp_done = 0;
        check_all("async_rst");
        @(posedge clk);
        #1;
        check_all("rst_hold");
        rst_ = 1'b1;

        // clr and load together: clr wins
        ena = 1'b0; clr = 1'b1; load = 1'b1; load_val = 4'd7; dir = 1'b1;
        cycle("clr_vs_load");
        check("clr_vs_load.count", int'(count), 0);
        clr = 1'b0; load = 1'b0;

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            ena = ($urandom_range(0, 9) < 8);
            clr = ($urandom_range(0, 39) == 0);
            load = ($urandom_range(0, 29) == 0);
            load_val = W'($urandom);
            if ($urandom_range(0, 49) == 0) mod_val = W'($urandom);
            if ($urandom_range(0, 19) == 0) dir = ~dir;
            if ($urandom_range(0, 29) == 0) mode = 2'($urandom);
            cycle("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
